// File: rtl/clock_monitor.sv
// Frequency monitor: counts sig_in rising edges over a GATE_CYCLES window of clk100M.
// Optional loss-of-signal detection is built when CLOCK_MONITOR_LOSS_DETECT_EN is defined.
module clock_monitor #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 16,
  parameter int LO_LIMIT    = 90,
  parameter int HI_LIMIT    = 110,
  parameter int LOSS_CYCLES = 64
) (
  input  logic             clk100M,
  input  logic             rstn,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] edge_count,
  output logic             count_valid,
  output logic             in_range,
  output logic             overflow,
  output logic             sig_lost
);

  localparam int                GATE_W    = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    REPORT
  } state_t;

  state_t            state_q, state_d;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              sync_meta, sync_q, sync_qq;
  logic              edge_det;
  logic              saturated;
  logic              cnt_in_limits;
  logic [63:0]       cnt_ext;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, which is what makes this a shift chain.
  always_ff @(posedge clk100M or negedge rstn) begin
    if (!rstn) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_qq   <= 1'b0;
    end else begin
      sync_meta <= sig_in;
      sync_q    <= sync_meta;
      sync_qq   <= sync_q;
    end
  end

  assign edge_det = sync_q & ~sync_qq;

  always_ff @(posedge clk100M or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = GATE;
      GATE: begin
        if (!enable)                    state_d = IDLE;
        else if (gate_cnt == GATE_LAST) state_d = REPORT;
      end
      REPORT:  state_d = enable ? GATE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A window that hit the ceiling is never in range, whatever the limits say.
  assign cnt_ext       = 64'(edge_cnt);
  assign saturated     = (edge_cnt == CNT_MAX);
  assign cnt_in_limits = (cnt_ext >= 64'(LO_LIMIT)) && (cnt_ext <= 64'(HI_LIMIT));

  always_ff @(posedge clk100M or negedge rstn) begin
    if (!rstn) begin
      gate_cnt    <= '0;
      edge_cnt    <= '0;
      edge_count  <= '0;
      count_valid <= 1'b0;
      in_range    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
        GATE: begin
          gate_cnt <= gate_cnt + 1'b1;
          if (edge_det && !saturated) edge_cnt <= edge_cnt + 1'b1;
        end
        REPORT: begin
          edge_count  <= edge_cnt;
          overflow    <= saturated;
          in_range    <= !saturated && cnt_in_limits;
          count_valid <= 1'b1;
          gate_cnt    <= '0;
          // An edge landing in the report cycle opens the next window's count.
          edge_cnt    <= edge_det ? CNT_W'(1) : '0;
        end
        default: begin
          gate_cnt <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

`ifdef CLOCK_MONITOR_LOSS_DETECT_EN
  localparam int                LOSS_W    = $clog2(LOSS_CYCLES + 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_FULL = LOSS_W'(LOSS_CYCLES);

  logic [LOSS_W-1:0] silence;

  // The silence counter parks at LOSS_CYCLES so sig_lost stays set until an edge returns.
  always_ff @(posedge clk100M or negedge rstn) begin
    if (!rstn) begin
      silence  <= '0;
      sig_lost <= 1'b0;
    end else if (!enable || edge_det) begin
      silence  <= '0;
      sig_lost <= 1'b0;
    end else if (silence != LOSS_FULL) begin
      silence <= silence + 1'b1;
      if (silence == LOSS_LAST) sig_lost <= 1'b1;
    end
  end
`else
  assign sig_lost = 1'b0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: table of steady periods plus boundary-edge,
// abort, asynchronous reset and loss-of-signal sequences on three parameterisations.
module tb_clock_monitor;

  logic        clk100M = 1'b0;
  logic        rstn    = 1'b0;
  logic        sig_in  = 1'b0;
  logic        enable  = 1'b0;

  logic [15:0] edge_count_a, edge_count_c;
  logic [3:0]  edge_count_b;
  logic        count_valid_a, in_range_a, overflow_a, sig_lost_a;
  logic        count_valid_b, in_range_b, overflow_b, sig_lost_b;
  logic        count_valid_c, in_range_c, overflow_c, sig_lost_c;

  always #5 clk100M = ~clk100M;

  clock_monitor dut_a (
    .clk100M(clk100M), .rstn(rstn), .sig_in(sig_in), .enable(enable),
    .edge_count(edge_count_a), .count_valid(count_valid_a), .in_range(in_range_a),
    .overflow(overflow_a), .sig_lost(sig_lost_a)
  );

  clock_monitor #(.CNT_W(4)) dut_b (
    .clk100M(clk100M), .rstn(rstn), .sig_in(sig_in), .enable(enable),
    .edge_count(edge_count_b), .count_valid(count_valid_b), .in_range(in_range_b),
    .overflow(overflow_b), .sig_lost(sig_lost_b)
  );

  clock_monitor #(.LO_LIMIT(100), .HI_LIMIT(125)) dut_c (
    .clk100M(clk100M), .rstn(rstn), .sig_in(sig_in), .enable(enable),
    .edge_count(edge_count_c), .count_valid(count_valid_c), .in_range(in_range_c),
    .overflow(overflow_c), .sig_lost(sig_lost_c)
  );

`ifdef CLOCK_MONITOR_LOSS_DETECT_EN
  localparam bit LOSS_ON = 1'b1;
`else
  localparam bit LOSS_ON = 1'b0;
`endif
  localparam int LOSS = 64;

  typedef struct {
    int period;
    int cnt_a;
    bit in_a;
    bit ovf_a;
    int cnt_b;
    bit ovf_b;
    bit in_b;
    bit in_c;
  } vec_t;

  typedef struct {
    int cyc;
    int cnt_a;
    bit in_a;
    bit ovf_a;
    int cnt_b;
    bit ovf_b;
    bit in_b;
    bit in_c;
    bit cv_b;
    bit cv_c;
  } rec_t;

  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   period = 10;
  int   ph     = 0;
  bit   gen_on = 1'b0;
  int   last_rise = 0;
  rec_t q[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // One clk100M cycle: sample outputs at the negedge, then drive the next sig_in level.
  task automatic step();
    @(negedge clk100M);
    cyc++;
    if (count_valid_a)
      q.push_back('{cyc, int'(edge_count_a), in_range_a, overflow_a, int'(edge_count_b),
                    overflow_b, in_range_b, in_range_c, count_valid_b, count_valid_c});
    if (gen_on) begin
      ph     = (ph + 1 >= period) ? 0 : ph + 1;
      sig_in = (ph < period / 2);
      if (ph == 0) last_rise = cyc;
    end
  endtask

  task automatic run_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic go_idle();
    enable = 1'b0;
    gen_on = 1'b0;
    sig_in = 1'b0;
    repeat (4) step();
    q.delete();
  endtask

  // Enable and a fresh sig_in rise land on the same negedge, fixing the edge phase.
  task automatic start_run(input int p, output int c0);
    go_idle();
    enable    = 1'b1;
    period    = p;
    ph        = 0;
    sig_in    = 1'b1;
    gen_on    = 1'b1;
    last_rise = cyc;
    c0        = cyc;
  endtask

  task automatic wait_report(input string name, input int budget, output rec_t r, output bit got);
    int n;
    n = 0;
    while (q.size() == 0 && n < budget) begin
      step();
      n++;
    end
    got = (q.size() > 0);
    if (got) r = q.pop_front();
    else begin
      total++;
      $display("FAIL %s: no count_valid within %0d cycles", name, budget);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    rec_t r;
    bit   got;
    int   c0;
    int   rise;

    vecs[0] = '{10, 100, 1'b1, 1'b0, 15, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{ 8, 125, 1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{20,  50, 1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{ 5, 200, 1'b0, 1'b0, 15, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{100, 10, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0};

    // Reset state
    repeat (3) step();
    check("rst_edge_count", int'(edge_count_a), 0);
    check("rst_count_valid", int'(count_valid_a), 0);
    check("rst_in_range", int'(in_range_a), 0);
    check("rst_overflow", int'(overflow_a), 0);
    check("rst_sig_lost", int'(sig_lost_a), 0);
    rstn = 1'b1;
    repeat (2) step();

    // Steady periods from IDLE: first window holds exactly 1000/period edges.
    for (int i = 0; i < 5; i++) begin
      start_run(vecs[i].period, c0);
      wait_report("vec_report", 1100, r, got);
      if (got) begin
        check($sformatf("vec%0d_latency", i), r.cyc - c0, 1002);
        check($sformatf("vec%0d_cnt_a", i), r.cnt_a, vecs[i].cnt_a);
        check($sformatf("vec%0d_in_a", i), int'(r.in_a), int'(vecs[i].in_a));
        check($sformatf("vec%0d_ovf_a", i), int'(r.ovf_a), int'(vecs[i].ovf_a));
        check($sformatf("vec%0d_cnt_b", i), r.cnt_b, vecs[i].cnt_b);
        check($sformatf("vec%0d_ovf_b", i), int'(r.ovf_b), int'(vecs[i].ovf_b));
        check($sformatf("vec%0d_in_b", i), int'(r.in_b), int'(vecs[i].in_b));
        check($sformatf("vec%0d_in_c", i), int'(r.in_c), int'(vecs[i].in_c));
        check($sformatf("vec%0d_cv_bc", i), int'(r.cv_b & r.cv_c), 1);
      end
      if (i == 0) begin
        wait_report("cont_report", 1100, r, got);
        if (got) begin
          check("cont_period", r.cyc - c0, 2003);
          check("cont_cnt_a", r.cnt_a, 100);
          check("cont_in_a", int'(r.in_a), 1);
        end
      end
    end

    // Single edges in the last GATE cycle (999) and in the REPORT cycle of window 2 (2001).
    go_idle();
    enable = 1'b1;
    c0     = cyc;
    run_until(c0 + 998);
    sig_in = 1'b1;
    step();
    sig_in = 1'b0;
    run_until(c0 + 2000);
    sig_in = 1'b1;
    step();
    sig_in = 1'b0;
    wait_report("bnd_w1", 1200, r, got);
    if (got) check("bnd_last_gate_edge", r.cnt_a, 1);
    wait_report("bnd_w2", 1200, r, got);
    if (got) begin
      check("bnd_w2_period", r.cyc - c0, 2003);
      check("bnd_w2_cnt", r.cnt_a, 0);
    end
    wait_report("bnd_w3", 1200, r, got);
    if (got) check("bnd_report_edge_next", r.cnt_a, 1);

    // Abort mid-window, then re-enable for a fresh window.
    start_run(10, c0);
    wait_report("abort_w1", 1100, r, got);
    if (got) check("abort_w1_cnt", r.cnt_a, 100);
    run_until(c0 + 1501);
    enable = 1'b0;
    run_until(c0 + 2701);
    check("abort_no_valid", q.size(), 0);
    check("abort_hold_cnt", int'(edge_count_a), 100);
    check("abort_hold_in", int'(in_range_a), 1);
    check("abort_hold_ovf_b", int'(overflow_b), 1);
    start_run(10, c0);
    wait_report("reenable", 1100, r, got);
    if (got) begin
      check("reenable_latency", r.cyc - c0, 1002);
      check("reenable_cnt", r.cnt_a, 100);
    end

    // Asynchronous reset mid-GATE, checked before any clock edge.
    start_run(10, c0);
    wait_report("arst_w1", 1100, r, got);
    run_until(c0 + 1500);
    #2 rstn = 1'b0;
    #1;
    check("arst_edge_count", int'(edge_count_a), 0);
    check("arst_in_range", int'(in_range_a), 0);
    check("arst_overflow_b", int'(overflow_b), 0);
    check("arst_edge_count_b", int'(edge_count_b), 0);
    check("arst_count_valid", int'(count_valid_a), 0);
    check("arst_sig_lost", int'(sig_lost_a), 0);
    repeat (3) step();
    while (ph != period / 2 + 1) step();
    rstn = 1'b1;
    c0   = cyc;
    q.delete();
    wait_report("arst_release", 1100, r, got);
    if (got) begin
      check("arst_latency", r.cyc - c0, 1002);
      check("arst_cnt", r.cnt_a, 100);
    end

    // Loss of signal: stop after a fall, watch sig_lost set and clear.
    start_run(10, c0);
    run_until(c0 + 300);
    check("loss_steady", int'(sig_lost_a), 0);
    while (ph != period / 2) step();
    gen_on = 1'b0;
    sig_in = 1'b0;
    rise   = last_rise;
    run_until(rise + LOSS + 2);
    check("loss_not_yet", int'(sig_lost_a), 0);
    step();
    check("loss_set", int'(sig_lost_a), int'(LOSS_ON));
    check("loss_set_b", int'(sig_lost_b), int'(LOSS_ON));
    run_until(rise + 100);
    check("loss_held", int'(sig_lost_a), int'(LOSS_ON));
    ph     = 0;
    sig_in = 1'b1;
    gen_on = 1'b1;
    rise   = cyc;
    run_until(rise + 2);
    check("loss_before_clear", int'(sig_lost_a), int'(LOSS_ON));
    step();
    check("loss_cleared", int'(sig_lost_a), 0);
    while (ph != period / 2) step();
    gen_on = 1'b0;
    sig_in = 1'b0;
    rise   = last_rise;
    run_until(rise + 70);
    check("loss_reset_again", int'(sig_lost_a), int'(LOSS_ON));
    enable = 1'b0;
    step();
    check("loss_enable_clear", int'(sig_lost_a), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/clock_monitor.md
CLOCK_MONITOR -- requirements
Module: clock_monitor

Interface
REQ-001 SHALL provide parameter GATE_CYCLES, default 1000: measurement window length in clk100M cycles (min 4).
REQ-002 SHALL provide parameter CNT_W, default 16: edge_count width.
REQ-003 SHALL provide parameter LO_LIMIT, default 90: minimum in-range edge count.
REQ-004 SHALL provide parameter HI_LIMIT, default 110: maximum in-range edge count.
REQ-005 SHALL provide parameter LOSS_CYCLES, default 64: cycles without an edge before loss is flagged.
REQ-006 SHALL have port clk100M  input  1  sole clock, all logic on the rising edge.
REQ-007 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-008 SHALL have port sig_in  input  1  monitored clock/signal, asynchronous to clk100M, frequency below clk100M/4.
REQ-009 SHALL have port enable  input  1  level; high = measure continuously.
REQ-010 SHALL have port edge_count  output  CNT_W  rising edges counted in the last completed window.
REQ-011 SHALL have port count_valid  output  1  one-cycle pulse when edge_count updates.
REQ-012 SHALL have port in_range  output  1  LO_LIMIT <= edge_count <= HI_LIMIT for the last window.
REQ-013 SHALL have port overflow  output  1  last window saturated the edge counter.
REQ-014 SHALL have port sig_lost  output  1  no sig_in edge for LOSS_CYCLES cycles.

Function
REQ-015 SHALL pass sig_in through a 2-flop synchronizer, then a rising-edge detector (sync_q & ~sync_qq); sig_in rise to counted edge = 3 clk100M cycles.
REQ-016 SHALL implement FSM states IDLE, GATE, REPORT.
REQ-017 IDLE: gate and edge counters held at 0; enable=1 -> GATE next cycle.
REQ-018 GATE: gate counter increments every cycle; detected edge increments edge counter; gate counter == GATE_CYCLES-1 -> REPORT.
REQ-019 An edge detected in the last GATE cycle SHALL be counted in that window.
REQ-020 REPORT (exactly 1 cycle): latch edge_count, overflow, in_range; pulse count_valid; -> GATE if enable, else IDLE.
REQ-021 An edge detected during REPORT SHALL be the first count of the next window (edge counter loads 1, else 0).
REQ-022 Edge counter SHALL saturate at 2^CNT_W-1; a window that saturates reports overflow=1 and in_range=0.
REQ-023 enable falling during GATE SHALL abort to IDLE next cycle: no count_valid, edge_count/in_range/overflow hold prior values.
REQ-024 edge_count, in_range and overflow SHALL change only in REPORT.
REQ-025 Window-to-window period SHALL be exactly GATE_CYCLES+1 cycles while enable stays high.

Reset
REQ-026 rstn low SHALL asynchronously force state=IDLE, counters, synchronizer flops, edge_count=0, count_valid=0, in_range=0, overflow=0, sig_lost=0.
REQ-027 Release SHALL be synchronous to clk100M; first window starts no earlier than the cycle after rstn samples high with enable=1.

Configuration
REQ-028 Macro CLOCK_MONITOR_LOSS_DETECT_EN SHALL control loss detection.
REQ-029 With CLOCK_MONITOR_LOSS_DETECT_EN: while enable=1 a silence counter counts cycles since the last detected edge (cleared on edge); reaching LOSS_CYCLES sets sig_lost, held until the next detected edge (clears the cycle after detection) or enable=0.
REQ-030 Without CLOCK_MONITOR_LOSS_DETECT_EN: no silence counter is built; sig_lost is constant 0.

Verification
REQ-031 GATE_CYCLES=1000, sig_in period 10 cycles, enable=1 -> count_valid every 1001 cycles, edge_count=100, in_range=1, overflow=0.
REQ-032 sig_in period 8 cycles -> edge_count=125, in_range=0.
REQ-033 CNT_W=4, sig_in period 10 -> edge_count=15, overflow=1, in_range=0.
REQ-034 enable dropped at gate cycle 500 -> no count_valid, edge_count retains previous 100; re-enable -> fresh window result 100.
REQ-035 Macro defined, sig_in held low from cycle T -> sig_lost=1 within LOSS_CYCLES+3 cycles of last edge; sig_in resumes -> sig_lost=0 within 4 cycles; macro undefined -> sig_lost stays 0.
REQ-036 rstn pulsed low mid-GATE -> all outputs 0 immediately without a clock edge; after release, first count_valid 1001 cycles after GATE entry.
